uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares one UART transmitter among N byte requesters.
//  Latches the winning byte and its parity type, issues a one-cycle tx_start, then waits for tx_done.
//  Enforces an idle gap between frames and returns a done pulse to the requester that was served.
//  Sits between the on-chip message producers and the single uart_tx instance on the 3.125 MHz clock.
// PARAMETERS
//  N_REQ       4    number of requesters (2..8)
//  GAP_CYCLES  2    idle clk_3125 cycles after tx_done before the next arbitration (0 allowed)
//  TIMEOUT_CYC 200  cycles in WAIT before the frame is abandoned (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clk_3125        in   1        system clock, 3.125 MHz
//  rst_n           in   1        synchronous reset, active-low
//  req             in   N_REQ    per-requester request; held high with data stable until grant
//  req_data        in   8*N_REQ  byte i in req_data[8*i+7:8*i]
//  req_parity      in   N_REQ    parity_type per requester (1 = odd, 0 = even)
//  grant           out  N_REQ    one-hot, one-cycle pulse: byte accepted, requester may change data
//  done            out  N_REQ    one-hot, one-cycle pulse: frame for that requester finished
//  tx_start        out  1        one-cycle start strobe to transmitter
//  tx_data         out  8        latched byte; stable from tx_start until tx_done
//  tx_parity_type  out  1        latched parity select; stable like tx_data
//  tx_done         in   1        one-cycle completion pulse from transmitter
//  busy            out  1        high in every state except IDLE
//  timeout_err     out  1        sticky error flag (present only with UART_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE, rr_ptr=0, grant=0, done=0, tx_start=0,
//   tx_data=8'h00, tx_parity_type=0, busy=0, timeout_err=0. Mid-frame reset abandons the frame; no done.
//  FSM: IDLE -> LAUNCH -> WAIT -> GAP -> IDLE (GAP skipped when GAP_CYCLES=0).
//   IDLE:   if |req, pick first set bit at or after rr_ptr (wrapping); in the same cycle register
//           grant[w]=1, tx_data/tx_parity_type from w, owner=w, rr_ptr=(w+1)%N_REQ; go LAUNCH.
//   LAUNCH: tx_start=1 for exactly this cycle; go WAIT.
//   WAIT:   on tx_done: done[owner]=1 next cycle; go GAP (or IDLE if GAP_CYCLES=0).
//           tx_done seen in IDLE/LAUNCH/GAP is ignored.
//   GAP:    count GAP_CYCLES cycles, then IDLE.
//  Latency: req rises in IDLE -> grant pulse 1 cycle later -> tx_start 1 cycle after grant.
//  Fairness: requester just served has lowest priority next round; no starvation with all req high.
//  req dropped before grant: withdrawn, not served. req kept high after grant: new request.
//  rr_ptr wraps N_REQ-1 -> 0. Only one outstanding frame ever; grant, done, tx_start mutually one-hot in time.
// CONFIGURATION
//  `define UART_ARB_TIMEOUT_EN: WAIT counts cycles; at TIMEOUT_CYC without tx_done sets timeout_err
//   (sticky until reset), drops the frame with no done pulse, goes GAP. Without it: no counter,
//   timeout_err port absent, WAIT holds indefinitely.
// STRUCTURE
//  Package uart_arb_pkg: state encoding (IDLE, LAUNCH, WAIT, GAP), width helper for owner/rr_ptr
//   ($clog2(N_REQ)), default GAP/TIMEOUT constants.
//  Sub-module rr_picker: combinational round-robin select (req, rr_ptr -> one-hot win, index, valid).
// TESTING
//  Single req[1]=1, data 8'hA5, parity 1 -> grant=4'b0010, tx_start next cycle, tx_data=8'hA5,
//   tx_parity_type=1; tx_done -> done=4'b0010, busy low after 2 GAP cycles.
//  All req high, rr_ptr=0 -> grant order 0,1,2,3,0 across five frames; each served exactly once per round.
//  req[2] dropped before grant while frame 0 runs -> requester 2 skipped, no grant/done for it.
//  rst_n low during WAIT -> next cycle all outputs at reset values; later tx_done ignored, no done.
//  Spurious tx_done in IDLE and GAP -> no state change, no done pulse.
//  UART_ARB_TIMEOUT_EN, tx_done withheld -> timeout_err=1 at TIMEOUT_CYC, no done, next req served.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter (UART_ARB_TIMEOUT_EN adds the timeout default)
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  localparam int DEFAULT_N_REQ      = 4;
  localparam int DEFAULT_GAP_CYCLES = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int DEFAULT_TIMEOUT_CYC = 200;
`endif

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rtl/uart_tx_arbiter_rr_picker.sv - combinational round-robin select starting at rr_ptr
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  // Scan upward from rr_ptr with wrap-around; the first set request wins.
  always_comb begin
    int idx;
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sequencer sharing one uart_tx among N_REQ requesters (UART_ARB_TIMEOUT_EN adds WAIT timeout)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = DEFAULT_N_REQ,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
`endif
) (
  input  logic                 clk_3125,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_parity,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 tx_parity_type,
  input  logic                 tx_done,
  output logic                 busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam arb_state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  arb_state_t       state, next_state;
  logic [IDX_W-1:0] rr_ptr, owner;
  logic [N_REQ-1:0] pick_win;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [7:0]       pick_byte;
  logic             pick_par;
  logic [GAP_W-1:0] gap_cnt;
  logic             load;
  logic             frame_done;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]  wait_cnt;
  logic             expire;
`endif

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  // Byte and parity of the current winner, muxed by the one-hot select.
  always_comb begin
    pick_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_win[i]) pick_byte = req_data[8*i +: 8];
    end
    pick_par = |(pick_win & req_parity);
  end

  // State register.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; tx_done only matters while waiting on a frame.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    frame_done = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    expire     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          load       = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH: next_state = WAIT;
      WAIT: begin
        if (tx_done) begin
          frame_done = 1'b1;
          next_state = AFTER_FRAME;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          expire     = 1'b1;
          next_state = AFTER_FRAME;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, latched frame and rotating priority pointer.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      owner          <= '0;
      grant          <= '0;
      done           <= '0;
      tx_start       <= 1'b0;
      tx_data        <= 8'h00;
      tx_parity_type <= 1'b0;
    end else begin
      grant    <= '0;
      done     <= '0;
      tx_start <= (state == LAUNCH);
      if (load) begin
        grant          <= pick_win;
        tx_data        <= pick_byte;
        tx_parity_type <= pick_par;
        owner          <= pick_idx;
        rr_ptr         <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (frame_done) done <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
    end
  end

  // Idle gap counter, cleared whenever the FSM is outside GAP.
  always_ff @(posedge clk_3125) begin
    if (!rst_n)            gap_cnt <= '0;
    else if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
    else                   gap_cnt <= '0;
  end

`ifdef UART_ARB_TIMEOUT_EN
  // WAIT cycle counter and sticky abandonment flag.
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else               wait_cnt <= '0;
      if (expire) timeout_err <= 1'b1;
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule
